// File: rtl/fifo_rd_packer.sv
// Read-side consumer for the async FIFO: packs RATIO consecutive entries into one
// wide word on a valid/ready output, with flush of a partial word plus lane-keep mask.
module fifo_rd_packer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned RATIO = 4
) (
    input  logic                     rclk,
    input  logic                     rrst,
    input  logic                     rempty,
    input  logic [WIDTH-1:0]         rdata,
    output logic                     rinc,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH*RATIO-1:0]   out_data,
    output logic [RATIO-1:0]         out_keep
);

    localparam int unsigned CW = $clog2(RATIO + 1);
    localparam int unsigned FW = CW + 1;
    localparam int unsigned DW = WIDTH * RATIO;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pend_q;
    logic             fl_q, fl_d;
    logic [DW-1:0]    acc_q, acc_d, acc_cap;
    logic             out_valid_d;
    logic [DW-1:0]    out_data_d;
    logic [RATIO-1:0] out_keep_d;

    logic [FW-1:0]    fill;
    logic             out_free;
    logic             complete;
    logic             emit_held;
    logic             flush_ok;
    logic [RATIO-1:0] keep_mask;

    assign fill     = FW'(cnt_q) + FW'(pend_q);
    assign out_free = ~out_valid | out_ready;
    assign rinc     = ~rrst & ~rempty & ~fl_q & (fill < FW'(RATIO));
    assign complete = pend_q & (cnt_q == CW'(RATIO - 1));

    // Held word: either a full word waiting for the output, or a flushed partial one.
    assign emit_held = ~pend_q & out_free &
                       ((cnt_q == CW'(RATIO)) | (fl_q & (cnt_q != '0)));

    // Full words (including a completing capture) make flush redundant.
    assign flush_ok = flush & ~fl_q & (fill != '0) & (fill < FW'(RATIO));

    // Accumulator with the in-flight entry written into lane cnt.
    always_comb begin
        acc_cap = acc_q;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (pend_q && (cnt_q == CW'(i))) begin
                acc_cap[i*WIDTH +: WIDTH] = rdata;
            end
        end
    end

    always_comb begin
        keep_mask = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            keep_mask[i] = (CW'(i) < cnt_q);
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_cap;
        fl_d        = fl_q;
        out_valid_d = out_valid & ~out_ready;
        out_data_d  = out_data;
        out_keep_d  = out_keep;

        if (pend_q) begin
            cnt_d = cnt_q + CW'(1);
        end

        if (complete && out_free) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_cap;
            out_keep_d  = '1;
            cnt_d       = '0;
            acc_d       = '0;
            fl_d        = 1'b0;
        end else if (emit_held) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_q;
            out_keep_d  = keep_mask;
            cnt_d       = '0;
            acc_d       = '0;
            fl_d        = 1'b0;
        end else if (fl_q && !pend_q && (cnt_q == '0)) begin
            // A full word already carried the flushed lanes out.
            fl_d = 1'b0;
        end

        if (flush_ok) begin
            fl_d = 1'b1;
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            fl_q      <= 1'b0;
            acc_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            pend_q    <= rinc;
            fl_q      <= fl_d;
            acc_q     <= acc_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            out_keep  <= out_keep_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: FIFO model feeds entries, a monitor checks every accepted
// word against the queue of popped entries in FIFO order.
module tb_fifo_rd_packer;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned RATIO = 4;
    localparam int unsigned DW    = WIDTH * RATIO;

    logic             rclk = 1'b0;
    logic             rrst;
    logic             rempty;
    logic [WIDTH-1:0] rdata;
    logic             rinc;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data;
    logic [RATIO-1:0] out_keep;

    fifo_rd_packer #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .rempty    (rempty),
        .rdata     (rdata),
        .rinc      (rinc),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep)
    );

    always #5 rclk = ~rclk;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] fifo[$];
    logic [WIDTH-1:0] exp_q[$];
    logic [DW-1:0]    got_w[$];
    logic [RATIO-1:0] got_k[$];

    bit        allow_partial = 1'b0;
    bit        force_empty   = 1'b0;
    bit        rinc_seen     = 1'b0;
    int        pops          = 0;
    int        cyc           = 0;
    int        first_valid   = -1;
    logic [15:0] rinc_pat    = '0;
    int        base;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, expv);
        end
    endtask

    // One clock: sample at negedge, FIFO delivers popped data just after the edge.
    task automatic tick();
        bit pop;
        rempty = (fifo.size() == 0) || force_empty;
        @(negedge rclk);
        pop = rinc;
        if (rempty) chk("rinc_while_empty", 64'(rinc), 64'd0);
        if (pop) rinc_seen = 1'b1;
        rinc_pat = {rinc_pat[14:0], pop};
        if (out_valid && first_valid < 0) first_valid = cyc;
        @(posedge rclk);
        #1;
        cyc++;
        if (pop && fifo.size() != 0) begin
            rdata = fifo.pop_front();
            exp_q.push_back(rdata);
            pops++;
        end else begin
            rdata = WIDTH'($urandom);
        end
    endtask

    logic [DW-1:0]    prev_d;
    logic [RATIO-1:0] prev_k;
    bit               prev_stall = 1'b0;

    // Scoreboard monitor: each accepted lane must be the next popped FIFO entry.
    always @(negedge rclk) begin
        int unsigned      n;
        logic [RATIO-1:0] expk;
        logic [WIDTH-1:0] lane;
        if (rrst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", 64'(out_data), 64'(prev_d));
                chk("hold_keep", 64'(out_keep), 64'(prev_k));
            end
            if (out_valid && out_ready) begin
                n = $countones(out_keep);
                expk = '0;
                for (int unsigned i = 0; i < RATIO; i++) expk[i] = (i < n);
                chk("keep_shape", 64'(out_keep), 64'(expk));
                chk("keep_nonzero", 64'(n != 0), 64'd1);
                if (!allow_partial) chk("full_word", 64'(n), 64'(RATIO));
                for (int unsigned i = 0; i < RATIO; i++) begin
                    lane = out_data[i*WIDTH +: WIDTH];
                    if (i < n) begin
                        if (exp_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL lane_extra: got=%0h want=none", lane);
                        end else begin
                            chk("lane_data", 64'(lane), 64'(exp_q.pop_front()));
                        end
                    end else begin
                        chk("lane_zero", 64'(lane), 64'd0);
                    end
                end
                got_w.push_back(out_data);
                got_k.push_back(out_keep);
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            prev_k     = out_keep;
        end
    end

    initial begin
        rrst = 1'b1; flush = 1'b0; out_ready = 1'b0; rdata = '0; rempty = 1'b1;

        // Reset with data available: no pops, outputs zero.
        for (int i = 1; i <= 8; i++) fifo.push_back(WIDTH'(i * 17));
        tick(); tick();
        chk("reset_rinc", 64'(rinc), 64'd0);
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_data", 64'(out_data), 64'd0);
        chk("reset_keep", 64'(out_keep), 64'd0);

        // Sustained stream.
        rrst = 1'b0; out_ready = 1'b1; cyc = 0; first_valid = -1; rinc_pat = '0;
        repeat (12) tick();
        chk("stream_rinc_pattern", 64'(rinc_pat[11:0]), 64'hF78);
        chk("stream_first_valid", 64'(first_valid), 64'd5);
        chk("stream_words", 64'(got_w.size()), 64'd2);
        if (got_w.size() >= 2) begin
            chk("stream_w0", 64'(got_w[0]), 64'h44332211);
            chk("stream_k0", 64'(got_k[0]), 64'hF);
            chk("stream_w1", 64'(got_w[1]), 64'h88776655);
            chk("stream_k1", 64'(got_k[1]), 64'hF);
        end

        // Backpressure: one word held in output, one in accumulator.
        out_ready = 1'b0; pops = 0; base = got_w.size();
        for (int i = 1; i <= 12; i++) fifo.push_back(WIDTH'(i * 17));
        repeat (12) tick();
        rinc_seen = 1'b0;
        repeat (8) tick();
        chk("bp_pops", 64'(pops), 64'd8);
        chk("bp_rinc_stopped", 64'(rinc_seen), 64'd0);
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_data", 64'(out_data), 64'h44332211);
        out_ready = 1'b1;
        repeat (20) tick();
        chk("bp_words", 64'(got_w.size() - base), 64'd3);
        if (got_w.size() >= base + 3) begin
            chk("bp_w0", 64'(got_w[base]), 64'h44332211);
            chk("bp_w1", 64'(got_w[base+1]), 64'h88776655);
            chk("bp_w2", 64'(got_w[base+2]), 64'hCCBBAA99);
        end

        // Flush of a three-lane partial word, then a flush with nothing captured.
        allow_partial = 1'b1; base = got_w.size();
        fifo.push_back(8'hA1); fifo.push_back(8'hA2); fifo.push_back(8'hA3);
        repeat (6) tick();
        flush = 1'b1; cyc = 0; first_valid = -1;
        tick();
        flush = 1'b0;
        repeat (4) tick();
        chk("flush_latency", 64'(first_valid >= 0 && first_valid <= 2), 64'd1);
        chk("flush_words", 64'(got_w.size() - base), 64'd1);
        if (got_w.size() >= base + 1) begin
            chk("flush_data", 64'(got_w[base]), 64'h00A3A2A1);
            chk("flush_keep", 64'(got_k[base]), 64'h7);
        end
        base = got_w.size();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (5) tick();
        chk("flush_empty_ignored", 64'(got_w.size() - base), 64'd0);

        // Reset after two captures discards them.
        allow_partial = 1'b0;
        for (int i = 0; i < 6; i++) fifo.push_back(WIDTH'(8'hE1 + i));
        repeat (3) tick();
        rrst = 1'b1;
        repeat (2) tick();
        fifo.delete();
        exp_q.delete();
        for (int i = 1; i <= 4; i++) fifo.push_back(WIDTH'(i));
        base = got_w.size();
        rrst = 1'b0;
        repeat (10) tick();
        chk("rst_mid_words", 64'(got_w.size() - base), 64'd1);
        if (got_w.size() >= base + 1) begin
            chk("rst_mid_data", 64'(got_w[base]), 64'h04030201);
            chk("rst_mid_keep", 64'(got_k[base]), 64'hF);
        end

        // Random empty toggling, backpressure and flushes.
        allow_partial = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0 && fifo.size() < 16) fifo.push_back(WIDTH'($urandom));
            force_empty = ($urandom_range(0, 4) == 0);
            out_ready   = ($urandom_range(0, 2) != 0);
            flush       = ($urandom_range(0, 19) == 0);
            tick();
        end
        flush = 1'b0; force_empty = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 200 && fifo.size() != 0; i++) tick();
        chk("drain_fifo_empty", 64'(fifo.size()), 64'd0);
        repeat (8) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (8) tick();
        chk("drain_all_delivered", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side consumer for the asynchronous FIFO. Runs in the FIFO read clock domain and drains WIDTH-bit entries through the FIFO's `rinc`/`rempty`/`rdata` interface. Packs RATIO consecutive entries into one wide word and presents it on a valid/ready output toward downstream logic. Supports an explicit flush that emits a partially filled word with a lane-keep mask.

## Interface

- `WIDTH`, 8: FIFO entry width in bits.
- `RATIO`, 4: entries packed per output word; integer ≥ 2. Lane counter width is $clog2(RATIO+1).
- `rclk` in, 1: read-domain clock; all logic on the rising edge.
- `rrst` in, 1: reset, synchronous, active-high.
- `rempty` in, 1: FIFO empty flag.
- `rdata` in, WIDTH: FIFO read data; valid on the cycle after a `rinc` cycle.
- `rinc` out, 1: pop request to the FIFO; combinational from registered state and `rempty`.
- `flush` in, 1: single-cycle request to emit the partial word.
- `out_valid` out, 1: output word valid.
- `out_ready` in, 1: downstream accepts the word.
- `out_data` out, WIDTH*RATIO: packed word; lane i occupies bits [i*WIDTH +: WIDTH].
- `out_keep` out, RATIO: bit i set means lane i holds data.

## Operation

- State: `cnt` (lanes captured, 0..RATIO), `pend` (pop issued last cycle, data due now), `fl` (flush pending), accumulator, output register (`out_valid`, `out_data`, `out_keep`).
- fill = cnt + pend.
- `rinc` = ~rrst & ~rempty & ~fl & (fill < RATIO). `rinc` is never high while `rempty` is high.
- `pend` <= `rinc`. When `pend` is 1, `rdata` is written into lane `cnt` and `cnt` increments.
- Packing is little-endian: the first popped entry goes to lane 0 (LSBs). Unfilled lanes read 0.
- Output register is free when `out_valid` is 0, or when `out_valid` and `out_ready` are both 1 (same-cycle accept and reload).
- Word completes when a capture brings `cnt` to RATIO:
  - If the output register is free that cycle, the complete word, including the incoming entry, loads directly with `out_keep` all ones, and `cnt` goes to 0.
  - Otherwise `cnt` holds at RATIO. The word transfers on the first cycle the output register is free, and `cnt` goes to 0.
- Flush:
  - `flush` with fill = 0: ignored.
  - `flush` with `cnt` = RATIO: ignored, because the word is already full.
  - `flush` while `fl` = 1: ignored.
  - Otherwise `fl` is set and pops stop. Once `pend` = 0 and the output register is free, the partial word loads with `out_keep` = (1<<cnt)-1. Then `cnt` goes to 0 and `fl` clears.
  - A `flush` arriving on the same cycle as a completing capture is ignored.
- Output: `out_valid` stays high until accepted. `out_data` and `out_keep` are stable while `out_valid` is 1 and `out_ready` is 0. On accept with no reload, `out_valid` goes to 0; `out_data`/`out_keep` hold their last values.
- Reset: `cnt` = 0, `pend` = 0, `fl` = 0, accumulator 0, `out_valid` = 0, `out_data` = 0, `out_keep` = 0; `rinc` = 0 during reset.
  - Reset mid-word discards the captured lanes and any in-flight entry. The FIFO pointer has already advanced, so those entries are lost by design.

## Timing

- Pop to capture: 1 cycle, matching the FIFO's registered read.
- Latency, sustained stream with `out_ready` = 1: first `rinc` at cycle 0, `rinc` high on cycles 0..RATIO-1, last capture at cycle RATIO, `out_valid` at cycle RATIO+1.
- Throughput: one word per RATIO+1 cycles. Pops resume on cycle RATIO+1.
- Backpressure: at most one word in the output register plus one complete word in the accumulator. After that, `rinc` stays 0 until a transfer.
- Flush: `out_valid` rises no later than 2 cycles after `flush` when the output register is free.

## Test plan

- Reset: hold `rrst` = 1 with `rempty` = 0 → `rinc` = 0; `out_valid`, `out_data`, `out_keep` all 0.
- Stream (RATIO = 4): FIFO holds 0x11..0x88, `out_ready` = 1 → `rinc` pattern 1111 0 1111 0. Words 0x44332211 then 0x88776655, `out_keep` = 0xF each. First `out_valid` 5 cycles after first `rinc`.
- Backpressure: `out_ready` = 0 with 12 entries available → exactly 8 pops, then `rinc` stays 0 and `out_data` holds 0x44332211. Raise `out_ready` → three words in order, no loss or duplication.
- Flush: pop 0xA1, 0xA2, 0xA3, FIFO then empty, pulse `flush` → `out_data` = 0x00A3A2A1, `out_keep` = 0x7. A second `flush` with fill = 0 produces no output.
- Empty toggling: random `rempty` → `rinc` never high while `rempty` is high; output words are contiguous in FIFO order.
- Reset mid-word: assert `rrst` after 2 captures, then stream 0x01..0x04 → single word 0x04030201, `out_keep` = 0xF.
